// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback front end.
// Entry layout is {rd, data}; source IDs select the round-robin favourite.
package wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   typedef enum logic {WB_SRC_ALU = 1'b0, WB_SRC_MEM = 1'b1} wb_src_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with an age-ordered view (index 0 = oldest).
// Data view port exists only when WB_FORWARD_EN is defined.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  wb_entry_t                            push_ent,
   input  logic                                 pop,
   output logic                                 full,
   output logic                                 empty,
   output wb_entry_t                            head,
   output logic [DEPTH-1:0]                     view_vld,
`ifdef WB_FORWARD_EN
   output logic [DEPTH-1:0][XLEN-1:0]           view_data,
`endif
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     view_rd
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_ent;
   end

   // Rotate storage so the query logic sees entries oldest-first.
   always_comb begin
      view_vld = '0;
      view_rd  = '0;
`ifdef WB_FORWARD_EN
      view_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         view_vld[i] = (CW'(i) < count);
         view_rd[i]  = mem[rd_ptr + PW'(i)].rd;
`ifdef WB_FORWARD_EN
         view_data[i] = mem[rd_ptr + PW'(i)].data;
`endif
      end
   end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: round-robin ALU/load arbitration, FIFO drain, hazard query.
// Define WB_FORWARD_EN to return the youngest buffered data for each query address.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  hold,
   output logic                  wr_ena,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]       wr_data,
   input  logic [REG_ADDR_W-1:0] q_addr0,
   input  logic [REG_ADDR_W-1:0] q_addr1,
   output logic                  q_pending0,
   output logic                  q_pending1,
   output logic [XLEN-1:0]       q_data0,
   output logic [XLEN-1:0]       q_data1
);
   wb_src_t                           rr_ptr;
   logic                              full;
   logic                              empty;
   logic                              grant_alu;
   logic                              grant_mem;
   logic                              accept;
   logic                              push;
   wb_entry_t                         acc_ent;
   wb_entry_t                         head;
   logic [DEPTH-1:0]                  view_vld;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  view_rd;
`ifdef WB_FORWARD_EN
   logic [DEPTH-1:0][XLEN-1:0]        view_data;
`endif

   assign grant_alu = alu_valid & (~mem_valid | (rr_ptr == WB_SRC_ALU));
   assign grant_mem = mem_valid & (~alu_valid | (rr_ptr == WB_SRC_MEM));
   assign alu_ready = grant_alu & ~full & ~rst;
   assign mem_ready = grant_mem & ~full & ~rst;
   assign accept    = (alu_valid & alu_ready) | (mem_valid & mem_ready);

   always_comb begin
      acc_ent.rd   = grant_alu ? alu_rd : mem_rd;
      acc_ent.data = grant_alu ? alu_data : mem_data;
   end

   // x0 requests complete the handshake but never occupy a slot.
   assign push = accept & (acc_ent.rd != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= WB_SRC_ALU;
      end else if (accept && alu_valid && mem_valid) begin
         rr_ptr <= (rr_ptr == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
      end
   end

   assign wr_ena  = ~empty & ~hold & ~rst;
   assign wr_addr = head.rd;
   assign wr_data = head.data;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_ent  (acc_ent),
      .pop       (wr_ena),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .view_vld  (view_vld),
`ifdef WB_FORWARD_EN
      .view_data (view_data),
`endif
      .view_rd   (view_rd)
   );

   // Scanning oldest to youngest lets the last match win.
   always_comb begin
      q_pending0 = 1'b0;
      q_pending1 = 1'b0;
      q_data0    = '0;
      q_data1    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (view_vld[i] && (q_addr0 != '0) && (view_rd[i] == q_addr0)) begin
            q_pending0 = 1'b1;
`ifdef WB_FORWARD_EN
            q_data0 = view_data[i];
`endif
         end
         if (view_vld[i] && (q_addr1 != '0) && (view_rd[i] == q_addr1)) begin
            q_pending1 = 1'b1;
`ifdef WB_FORWARD_EN
            q_data1 = view_data[i];
`endif
         end
      end
   end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic against a queue model.
// Expected forwarded data follows WB_FORWARD_EN.
module tb_regfile_writeback;
   import wb_pkg::*;

   localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
   logic        alu_ready, mem_ready, wr_ena, q_pending0, q_pending1;
   logic [4:0]  alu_rd = '0, mem_rd = '0, q_addr0 = '0, q_addr1 = '0, wr_addr;
   logic [31:0] alu_data = '0, mem_data = '0, wr_data, q_data0, q_data1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_writeback #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .hold(hold), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .q_addr0(q_addr0), .q_addr1(q_addr1), .q_pending0(q_pending0), .q_pending1(q_pending1),
      .q_data0(q_data0), .q_data1(q_data1)
   );

   // Reference model: a queue of pending writes in acceptance order.
   wb_entry_t   mq[$];
   bit          m_rr_mem;
   logic        e_alu_rdy, e_mem_rdy, e_wr_ena, e_pend0, e_pend1;
   logic [4:0]  e_wr_addr;
   logic [31:0] e_wr_data, e_qd0, e_qd1;

   function automatic void model_eval();
      bit room;
      room = (mq.size() < DEPTH) && !rst;
      e_alu_rdy = 1'b0;
      e_mem_rdy = 1'b0;
      if (alu_valid && mem_valid) begin
         if (m_rr_mem) e_mem_rdy = room;
         else          e_alu_rdy = room;
      end else if (alu_valid) e_alu_rdy = room;
      else if (mem_valid)     e_mem_rdy = room;
      e_wr_ena  = (mq.size() > 0) && !hold && !rst;
      e_wr_addr = (mq.size() > 0) ? mq[0].rd : 5'd0;
      e_wr_data = (mq.size() > 0) ? mq[0].data : 32'd0;
      e_pend0 = 1'b0; e_pend1 = 1'b0; e_qd0 = '0; e_qd1 = '0;
      foreach (mq[i]) begin
         if (q_addr0 != 0 && mq[i].rd == q_addr0) begin e_pend0 = 1'b1; e_qd0 = FWD ? mq[i].data : 32'd0; end
         if (q_addr1 != 0 && mq[i].rd == q_addr1) begin e_pend1 = 1'b1; e_qd1 = FWD ? mq[i].data : 32'd0; end
      end
   endfunction

   task automatic tick();
      bit acc_alu, acc_mem, pop, both;
      wb_entry_t ent;
      model_eval();
      acc_alu = alu_valid && e_alu_rdy;
      acc_mem = mem_valid && e_mem_rdy;
      pop     = e_wr_ena;
      both    = alu_valid && mem_valid;
      ent.rd   = acc_alu ? alu_rd : mem_rd;
      ent.data = acc_alu ? alu_data : mem_data;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_rr_mem = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc_alu || acc_mem) begin
            if (ent.rd != 0) mq.push_back(ent);
            if (both) m_rr_mem = !m_rr_mem;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({wr_ena, wr_addr, wr_data} !== 38'd0) begin
         failures++; $display("FAIL reset_wr: got %0b/%0d/%h want 0/0/0", wr_ena, wr_addr, wr_data);
      end
      checks++;
      if ({q_pending0, q_pending1, q_data0, q_data1} !== 66'd0) begin
         failures++; $display("FAIL reset_query: got %0b %0b %h %h want all 0", q_pending0, q_pending1, q_data0, q_data1);
      end
      alu_valid = 1'b1; mem_valid = 1'b1;
      #1;
      checks++;
      if ({alu_ready, mem_ready} !== 2'b10) begin
         failures++; $display("FAIL reset_rr_favours_alu: got %b want 10", {alu_ready, mem_ready});
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
   endtask

   task automatic test_single();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; q_addr0 = 5'd5;
      #1;
      checks++;
      if (q_pending0 !== 1'b0 || alu_ready !== 1'b1) begin
         failures++; $display("FAIL single_accept: got rdy=%b pend=%b want rdy=1 pend=0", alu_ready, q_pending0);
      end
      tick();
      alu_valid = 1'b0;
      #1;
      checks++;
      if ({wr_ena, wr_addr, wr_data, q_pending0} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
         failures++; $display("FAIL single_write: got %b/%0d/%h pend=%b want 1/5/deadbeef pend=1", wr_ena, wr_addr, wr_data, q_pending0);
      end
      tick();
      #1;
      checks++;
      if (wr_ena !== 1'b0 || q_pending0 !== 1'b0) begin
         failures++; $display("FAIL single_after: got ena=%b pend=%b want 0 0", wr_ena, q_pending0);
      end
   endtask

   task automatic test_round_robin();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1_0001;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2_0002;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if ({alu_ready, mem_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {alu_ready, mem_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (i > 0) begin
            checks++;
            if ({wr_ena, wr_addr} !== {1'b1, ((i - 1) % 2 == 0) ? 5'd1 : 5'd2}) begin
               failures++; $display("FAIL rr_wr[%0d]: got %b/%0d want 1/%0d", i, wr_ena, wr_addr, ((i - 1) % 2 == 0) ? 1 : 2);
            end
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      checks++;
      if ({wr_ena, wr_addr, wr_data} !== {1'b1, 5'd2, 32'hB2B2_0002}) begin
         failures++; $display("FAIL rr_last: got %b/%0d/%h want 1/2/b2b20002", wr_ena, wr_addr, wr_data);
      end
      tick();
   endtask

   task automatic test_full();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(32'h100 * i + 7);
         #1;
         checks++;
         if (alu_ready !== (i < DEPTH)) begin
            failures++; $display("FAIL full_ready[%0d]: got %b want %b", i, alu_ready, i < DEPTH);
         end
         if (i < DEPTH) tick();
      end
      hold = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         checks++;
         if ({wr_ena, wr_addr, wr_data} !== {1'b1, 5'(10 + j), 32'(32'h100 * j + 7)}) begin
            failures++; $display("FAIL full_drain[%0d]: got %b/%0d/%h want 1/%0d/%h", j, wr_ena, wr_addr, wr_data, 10 + j, 32'h100 * j + 7);
         end
         if (j < 2) begin
            checks++;
            if (alu_ready !== (j == 1)) begin
               failures++; $display("FAIL full_push_pop[%0d]: got rdy=%b want %b", j, alu_ready, j == 1);
            end
         end
         tick();
         if (j == 1) alu_valid = 1'b0;
      end
      #1;
      checks++;
      if (wr_ena !== 1'b0) begin
         failures++; $display("FAIL full_empty: got ena=%b want 0", wr_ena);
      end
   endtask

   task automatic test_x0();
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234; q_addr0 = 5'd0;
      #1;
      checks++;
      if (mem_ready !== 1'b1) begin
         failures++; $display("FAIL x0_ready: got %b want 1", mem_ready);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      checks++;
      if (wr_ena !== 1'b0 || q_pending0 !== 1'b0) begin
         failures++; $display("FAIL x0_dropped: got ena=%b pend=%b want 0 0", wr_ena, q_pending0);
      end
   endtask

   task automatic test_forward_and_reset();
      hold = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11; tick();
      alu_data = 32'h22; tick();
      alu_rd = 5'd3; alu_data = 32'h33; tick();
      alu_valid = 1'b0; q_addr0 = 5'd7; q_addr1 = 5'd8;
      #1;
      checks++;
      if ({q_pending0, q_data0} !== {1'b1, FWD ? 32'h22 : 32'h0}) begin
         failures++; $display("FAIL fwd_youngest: got %b/%h want 1/%h", q_pending0, q_data0, FWD ? 32'h22 : 32'h0);
      end
      checks++;
      if ({q_pending1, q_data1} !== 33'd0) begin
         failures++; $display("FAIL fwd_nomatch: got %b/%h want 0/0", q_pending1, q_data1);
      end
      rst = 1'b1; tick(); rst = 1'b0; hold = 1'b0; q_addr1 = 5'd3;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if ({wr_ena, q_pending0, q_pending1} !== 3'b000) begin
            failures++; $display("FAIL reset_discard[%0d]: got ena=%b pend=%b%b want 000", k, wr_ena, q_pending0, q_pending1);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         alu_valid = ($urandom_range(0, 9) < 6); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
         mem_valid = ($urandom_range(0, 9) < 6); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         hold = ($urandom_range(0, 3) == 0);
         q_addr0 = 5'($urandom_range(0, 7)); q_addr1 = 5'($urandom_range(0, 7));
         #1;
         model_eval();
         checks++;
         if ({alu_ready, mem_ready, wr_ena, q_pending0, q_pending1} !== {e_alu_rdy, e_mem_rdy, e_wr_ena, e_pend0, e_pend1}) begin
            failures++; $display("FAIL rand_ctl[%0d]: got %b want %b", c, {alu_ready, mem_ready, wr_ena, q_pending0, q_pending1}, {e_alu_rdy, e_mem_rdy, e_wr_ena, e_pend0, e_pend1});
         end
         checks++;
         if ({wr_addr, wr_data} !== {e_wr_addr, e_wr_data}) begin
            failures++; $display("FAIL rand_wr[%0d]: got %0d/%h want %0d/%h", c, wr_addr, wr_data, e_wr_addr, e_wr_data);
         end
         checks++;
         if ({q_data0, q_data1} !== {e_qd0, e_qd1}) begin
            failures++; $display("FAIL rand_qdata[%0d]: got %h %h want %h %h", c, q_data0, q_data1, e_qd0, e_qd1);
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0; hold = 1'b0;
      for (int d = 0; d < DEPTH + 1; d++) tick();
      #1;
      checks++;
      if (wr_ena !== 1'b0 || mq.size() != 0) begin
         failures++; $display("FAIL rand_drain: got ena=%b model_left=%0d want 0 0", wr_ena, mq.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_x0();
      test_forward_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
